// File: rtl/mips_cpu_pkg.sv
// Shared MIPS core definitions: fetch state encoding, PC/trace geometry and
// target-composition helpers reused by fetch, decode and ALU.
package mips_cpu_pkg;

  localparam int unsigned PcWidth    = 32;
  localparam int unsigned TraceDepth = 16;
  localparam int unsigned TraceIdxW  = $clog2(TraceDepth);

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t StRun   = 2'd0;
  localparam fetch_state_t StHalt  = 2'd1;
  localparam fetch_state_t StFault = 2'd2;

  function automatic logic [PcWidth-1:0] jump_target(input logic [PcWidth-1:0] pc_plus4,
                                                     input logic [25:0]         index);
    return {pc_plus4[31:28], index, 2'b00};
  endfunction

  function automatic logic [PcWidth-1:0] sext_shift2(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_trace_buf.sv
// Ring buffer of retired-instruction PCs; read index 0 returns the newest entry.
module pc_trace_buf
  import mips_cpu_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [PcWidth-1:0]   wr_pc_i,
  input  logic [TraceIdxW-1:0] rd_idx_i,
  output logic [PcWidth-1:0]   rd_pc_o
);

  logic [PcWidth-1:0]   trace_q [TraceDepth];
  logic [TraceIdxW-1:0] wr_ptr_q;
  logic [TraceIdxW-1:0] rd_ptr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < TraceDepth; i++) begin
        trace_q[i] <= '0;
      end
      wr_ptr_q <= '0;
    end else if (wr_en_i) begin
      trace_q[wr_ptr_q] <= wr_pc_i;
      wr_ptr_q          <= wr_ptr_q + TraceIdxW'(1);
    end
  end

  // Depth is a power of two, so pointer arithmetic wraps for free.
  assign rd_ptr  = wr_ptr_q - TraceIdxW'(1) - rd_idx_i;
  assign rd_pc_o = trace_q[rd_ptr];

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, next-PC select, halt/fault detection and cycle/instruction counters.
// Optional PC history buffer enabled by defining PC_FETCH_TRACE_EN.
module pc_fetch_unit
  import mips_cpu_pkg::*;
#(
  parameter logic [PcWidth-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [PcWidth-1:0] HALT_PC0 = 32'h0000_0090,
  parameter logic [PcWidth-1:0] HALT_PC1 = 32'h0000_0098
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [15:0]        branch_imm,
  input  logic               jump,
  input  logic [25:0]        jump_index,
  input  logic               jump_reg,
  input  logic [PcWidth-1:0] reg_target,
  output logic [PcWidth-1:0] pc,
  output logic [PcWidth-1:0] pc_plus4,
  output logic               halted,
  output logic               fault,
  output logic [31:0]        cycle_count,
  output logic [31:0]        instr_count,
  input  logic [3:0]         trace_idx,
  output logic [PcWidth-1:0] trace_pc
);

  localparam fetch_state_t ResetState =
      ((RESET_PC == HALT_PC0) || (RESET_PC == HALT_PC1)) ? StHalt : StRun;

  fetch_state_t       state_q, state_d;
  logic [PcWidth-1:0] pc_q, pc_d;
  logic [31:0]        cycle_q, cycle_d;
  logic [31:0]        instr_q, instr_d;
  logic [PcWidth-1:0] target;
  logic               pc_upd;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    if (jump_reg) begin
      target = reg_target;
    end else if (jump) begin
      target = jump_target(pc_plus4, jump_index);
    end else if (branch_taken) begin
      target = pc_plus4 + sext_shift2(branch_imm);
    end else begin
      target = pc_plus4;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cycle_d = cycle_q;
    instr_d = instr_q;
    pc_upd  = 1'b0;
    if (state_q == StRun) begin
      cycle_d = (cycle_q == '1) ? cycle_q : cycle_q + 32'd1;
      if (!stall) begin
        if (target[1:0] != 2'b00) begin
          state_d = StFault;
        end else begin
          pc_d    = target;
          pc_upd  = 1'b1;
          instr_d = (instr_q == '1) ? instr_q : instr_q + 32'd1;
          if ((target == HALT_PC0) || (target == HALT_PC1)) begin
            state_d = StHalt;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ResetState;
      pc_q    <= RESET_PC;
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  assign pc          = pc_q;
  assign halted      = (state_q == StHalt);
  assign fault       = (state_q == StFault);
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;

`ifdef PC_FETCH_TRACE_EN
  pc_trace_buf u_trace (
    .clk_i    (clk),
    .rst_i    (rst),
    .wr_en_i  (pc_upd),
    .wr_pc_i  (pc_q),
    .rd_idx_i (trace_idx),
    .rd_pc_o  (trace_pc)
  );
`else
  logic unused_trace;
  assign unused_trace = ^{trace_idx, pc_upd};
  assign trace_pc     = '0;
`endif

endmodule
